pmp_unit: RTL and testbench

Parametrised physical memory protection unit holding up to 16 PMP entries (pmpcfg/pmpaddr CSRs at 0x3A0–0x3A3 and 0x3B0–0x3BF) and checking one access per request. It scans entries sequentially, one entry per cycle, with lowest-index-first priority and early exit on the first match. It sits between the CSR file and the load/store and fetch paths of the core.

---
 rtl/pmp_unit_if.sv | 33 +++
 rtl/pmp_unit.sv | 192 +++++++++++++++++++
 tb/tb_pmp_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pmp_unit_if.sv
// pmp_unit_if: CSR access and check request/response bundle for pmp_unit.
//   csr_*  : CSR write strobe/address/data, combinational read data, csr_ready
//   req_*  : access check request (address, op, privilege) with req_ready
//   resp_* : one-cycle result pulse plus registered allow/matched/index
// master = core side (CSR file, LSU/fetch), slave = pmp_unit.
interface pmp_unit_if #(
  parameter int XLEN = 32
);
  logic            csr_we;
  logic            csr_ready;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic [1:0]      req_op;
  logic            req_mmode;
  logic            resp_valid;
  logic            resp_allow;
  logic            resp_matched;
  logic [3:0]      resp_idx;

  modport master (
    output csr_we, csr_addr, csr_wdata, req_valid, req_addr, req_op, req_mmode,
    input  csr_ready, csr_rdata, req_ready, resp_valid, resp_allow, resp_matched, resp_idx
  );

  modport slave (
    input  csr_we, csr_addr, csr_wdata, req_valid, req_addr, req_op, req_mmode,
    output csr_ready, csr_rdata, req_ready, resp_valid, resp_allow, resp_matched, resp_idx
  );
endinterface

// File: rtl/pmp_unit.sv
// pmp_unit: physical memory protection checker with up to 16 entries.
// Holds pmpcfg0..3 (0x3A0-0x3A3) and pmpaddr0..15 (0x3B0-0x3BF). Each accepted
// request is scanned one entry per cycle, lowest index first, stopping at the
// first match; the result is presented with a one-cycle resp_valid pulse.
// Ports:
//   clk  - clock
//   rst  - asynchronous reset, active-high
//   bus  - pmp_unit_if.slave: CSR read/write, check request, check response
// XLEN must be at least 32 (pmpcfg words occupy the low 32 bits).
module pmp_unit #(
  parameter int NUM_ENTRIES = 16,
  parameter int XLEN        = 32
) (
  input logic       clk,
  input logic       rst,
  pmp_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] A_OFF   = 2'd0;
  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_EXEC  = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ENTRIES - 1);

  // Storage is always 16 deep; entries at or above NUM_ENTRIES are never
  // written, so they stay 0, read back as 0 and behave as OFF.
  logic [7:0]      cfg_q  [16];
  logic [XLEN-1:0] addr_q [16];
  logic            addr_lock [16];

  logic [1:0] state;
  logic [3:0] idx;
  logic       resp_allow_q;
  logic       resp_matched_q;
  logic [3:0] resp_idx_q;

  logic [XLEN-1:0] wa_p0;
  logic [1:0]      op_p0;
  logic            mmode_p0;

  logic            cfg_sel;
  logic            addr_sel;
  logic            csr_wr;
  logic [31:0]     cfg_word;
  logic [XLEN-1:0] rdata;

  logic [7:0]      cur_cfg;
  logic [XLEN-1:0] cur_a;
  logic [XLEN-1:0] prev_a;
  logic [XLEN-1:0] napot_mask;
  logic            hit;

  // Reserved bits read as zero and W without R is not a legal combination.
  function automatic logic [7:0] cfg_legalize(input logic [7:0] b);
    logic [7:0] r;
    r      = b;
    r[6:5] = 2'b00;
    if (r[1] && !r[0]) r[1] = 1'b0;
    return r;
  endfunction

  // Unlocked entries grant everything to M-mode; otherwise RWX apply.
  function automatic logic perm_ok(input logic [7:0] c, input logic [1:0] op,
                                   input logic mmode);
    logic ok;
    if (mmode && !c[7]) begin
      ok = 1'b1;
    end else begin
      case (op)
        OP_READ:  ok = c[0];
        OP_WRITE: ok = c[1];
        OP_EXEC:  ok = c[2];
        default:  ok = 1'b1;
      endcase
    end
    return ok;
  endfunction

  assign cfg_sel  = (bus.csr_addr[11:2] == 10'h0E8);
  assign addr_sel = (bus.csr_addr[11:4] == 8'h3B);
  assign csr_wr   = bus.csr_we && (state == S_IDLE);

  assign bus.req_ready    = (state == S_IDLE);
  assign bus.csr_ready    = (state == S_IDLE);
  assign bus.resp_valid   = (state == S_RESP);
  assign bus.resp_allow   = resp_allow_q;
  assign bus.resp_matched = resp_matched_q;
  assign bus.resp_idx     = resp_idx_q;
  assign bus.csr_rdata    = rdata;

  // pmpaddr[i] is frozen by its own lock, and also by a locked TOR entry
  // above it that uses it as the bottom of its range.
  always_comb begin
    for (int e = 0; e < 16; e++) addr_lock[e] = cfg_q[e][7];
    for (int e = 0; e < 15; e++) begin
      if (cfg_q[e+1][7] && (cfg_q[e+1][4:3] == A_TOR)) addr_lock[e] = 1'b1;
    end
  end

  always_comb begin
    cfg_word = '0;
    rdata    = '0;
    for (int j = 0; j < 4; j++) cfg_word[8*j +: 8] = cfg_q[{bus.csr_addr[1:0], 2'(j)}];
    if (cfg_sel)       rdata[31:0] = cfg_word;
    else if (addr_sel) rdata       = addr_q[bus.csr_addr[3:0]];
  end

  // Match evaluation for the entry currently being scanned.
  always_comb begin
    cur_cfg    = cfg_q[idx];
    cur_a      = addr_q[idx];
    prev_a     = (idx == 4'd0) ? '0 : addr_q[idx - 4'd1];
    napot_mask = cur_a ^ (cur_a + XLEN'(1));
    case (cur_cfg[4:3])
      A_OFF:   hit = 1'b0;
      A_TOR:   hit = (prev_a < cur_a) && (wa_p0 >= prev_a) && (wa_p0 < cur_a);
      A_NA4:   hit = (wa_p0 == cur_a);
      A_NAPOT: hit = ((wa_p0 & ~napot_mask) == (cur_a & ~napot_mask));
      default: hit = 1'b0;
    endcase
  end

  // Request capture (stage p0): held for the whole scan.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && bus.req_valid) begin
      wa_p0    <= bus.req_addr >> 2;
      op_p0    <= bus.req_op;
      mmode_p0 <= bus.req_mmode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      resp_allow_q   <= 1'b0;
      resp_matched_q <= 1'b0;
      resp_idx_q     <= '0;
      for (int e = 0; e < 16; e++) begin
        cfg_q[e]  <= '0;
        addr_q[e] <= '0;
      end
    end else begin
      if (csr_wr) begin
        for (int e = 0; e < 16; e++) begin
          if (e < NUM_ENTRIES) begin
            if (cfg_sel && (bus.csr_addr[1:0] == 2'(e / 4)) && !cfg_q[e][7])
              cfg_q[e] <= cfg_legalize(bus.csr_wdata[8*(e%4) +: 8]);
            if (addr_sel && (bus.csr_addr[3:0] == 4'(e)) && !addr_lock[e])
              addr_q[e] <= bus.csr_wdata;
          end
        end
      end

      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            state <= S_SCAN;
            idx   <= '0;
          end
        end
        S_SCAN: begin
          if (hit) begin
            state          <= S_RESP;
            resp_allow_q   <= perm_ok(cur_cfg, op_p0, mmode_p0);
            resp_matched_q <= 1'b1;
            resp_idx_q     <= idx;
          end else if (idx == LAST_IDX) begin
            state          <= S_RESP;
            resp_allow_q   <= mmode_p0;
            resp_matched_q <= 1'b0;
            resp_idx_q     <= '0;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmp_unit.sv
module tb_pmp_unit;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pmp_unit_if #(.XLEN(32)) bus ();

  pmp_unit #(.NUM_ENTRIES(16), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_addr = a;
    #1;
    check(tag, bus.csr_rdata, exp);
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.csr_we    = 1'b1;
    bus.csr_addr  = a;
    bus.csr_wdata = d;
    @(negedge clk);
    bus.csr_we    = 1'b0;
  endtask

  // Issues one request (optionally with a CSR write in the accept cycle) and
  // checks latency (accept cycle = 0) and the registered result.
  task automatic do_req(input string tag, input logic [31:0] a, input logic [1:0] op,
                        input logic mm, input logic do_wr, input logic [11:0] wr_a,
                        input logic [31:0] wr_d, input logic e_allow, input logic e_match,
                        input logic [3:0] e_idx, input int e_lat);
    int cyc;
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_op    = op;
    bus.req_mmode = mm;
    if (do_wr) begin
      bus.csr_we    = 1'b1;
      bus.csr_addr  = wr_a;
      bus.csr_wdata = wr_d;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.csr_we    = 1'b0;
    cyc = 1;
    check({tag, "_busy"}, {30'd0, bus.req_ready, bus.csr_ready}, 32'd0);
    while (bus.resp_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(e_lat));
    check({tag, "_allow"}, {31'd0, bus.resp_allow}, {31'd0, e_allow});
    check({tag, "_matched"}, {31'd0, bus.resp_matched}, {31'd0, e_match});
    check({tag, "_idx"}, {28'd0, bus.resp_idx}, {28'd0, e_idx});
    @(negedge clk);
    check({tag, "_after"}, {29'd0, bus.req_ready, bus.resp_valid, bus.resp_allow},
          {29'd0, 1'b1, 1'b0, e_allow});
  endtask

  initial begin
    int cyc;
    int seen;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.csr_we    = 1'b0;
    bus.csr_addr  = 12'h000;
    bus.csr_wdata = 32'h0;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_op    = 2'd0;
    bus.req_mmode = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready", {30'd0, bus.req_ready, bus.csr_ready}, 32'd3);
    check("rst_resp", {28'd0, bus.resp_valid, bus.resp_allow, bus.resp_matched, 1'b0}, 32'd0);
    check("rst_idx", {28'd0, bus.resp_idx}, 32'd0);
    rd_check("rst_cfg0", 12'h3A0, 32'h0);
    rd_check("rst_addr5", 12'h3B5, 32'h0);
    rd_check("non_pmp", 12'h300, 32'h0);
    do_req("nomatch_u", 32'h0000_1234, 2'd0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 4'd0, 17);
    do_req("nomatch_m", 32'h0000_1234, 2'd1, 1'b1, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 4'd0, 17);

    // TOR entry 0: words [0, 0x1000)
    csr_write(12'h3B0, 32'h0000_1000);
    csr_write(12'h3A0, 32'h0000_000B);
    rd_check("tor_cfg", 12'h3A0, 32'h0000_000B);
    do_req("tor_in", 32'h0000_3FFC, 2'd1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 4'd0, 2);
    do_req("tor_edge", 32'h0000_4000, 2'd1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 4'd0, 17);

    // NAPOT entry 3: bytes 0x800..0xFFF, X only; entry 0 turned off
    csr_write(12'h3B3, 32'h0000_02FF);
    csr_write(12'h3A0, 32'h1C00_0000);
    rd_check("napot_cfg", 12'h3A0, 32'h1C00_0000);
    do_req("napot_x", 32'h0000_0FFC, 2'd2, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 4'd3, 5);
    do_req("napot_r", 32'h0000_0800, 2'd0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 4'd3, 5);
    do_req("napot_none", 32'h0000_0800, 2'd3, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 4'd3, 5);
    do_req("napot_below", 32'h0000_07FC, 2'd2, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 4'd0, 17);

    // Priority: NA4 entries 1 (R) and 2 (no perms) both at byte 0x100;
    // cfg written in the same cycle the request is accepted.
    csr_write(12'h3B1, 32'h0000_0040);
    csr_write(12'h3B2, 32'h0000_0040);
    do_req("prio", 32'h0000_0100, 2'd0, 1'b0, 1'b1, 12'h3A0, 32'h1C10_1100,
           1'b1, 1'b1, 4'd1, 3);
    rd_check("prio_cfg", 12'h3A0, 32'h1C10_1100);
    do_req("na4_miss", 32'h0000_0104, 2'd0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 4'd0, 17);

    // CSR write while a scan is in flight is ignored
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_9000;
    bus.req_op    = 2'd0;
    bus.req_mmode = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.csr_we    = 1'b1;
    bus.csr_addr  = 12'h3B5;
    bus.csr_wdata = 32'h0000_1234;
    check("busy_csr_ready", {31'd0, bus.csr_ready}, 32'd0);
    cyc = 1;
    while (bus.resp_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    bus.csr_we = 1'b0;
    check("busy_lat", 32'(cyc), 32'd17);
    rd_check("busy_write_ignored", 12'h3B5, 32'h0);

    // Locking
    csr_write(12'h3B0, 32'h0000_0100);
    csr_write(12'h3A0, 32'h0000_0088);
    do_req("lock_m", 32'h0000_0010, 2'd0, 1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 4'd0, 2);
    csr_write(12'h3B0, 32'h0);
    csr_write(12'h3A0, 32'h0);
    rd_check("lock_addr0", 12'h3B0, 32'h0000_0100);
    rd_check("lock_cfg0", 12'h3A0, 32'h0000_0088);
    csr_write(12'h3B2, 32'h0000_0055);
    csr_write(12'h3A0, 32'h8800_0000);
    rd_check("lock_cfg3", 12'h3A0, 32'h8800_0088);
    csr_write(12'h3B2, 32'h0000_0077);
    rd_check("tor_lock_addr2", 12'h3B2, 32'h0000_0055);
    do_req("lock_tor3", 32'h0000_0400, 2'd2, 1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 4'd3, 5);

    // Reset during SCAN aborts the check
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0400;
    bus.req_op    = 2'd0;
    bus.req_mmode = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", {30'd0, bus.req_ready, bus.resp_valid}, 32'd2);
    rst  = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) seen++;
    end
    check("abort_no_resp", 32'(seen), 32'd0);
    rd_check("abort_cfg_cleared", 12'h3A0, 32'h0);
    rd_check("abort_addr_cleared", 12'h3B2, 32'h0);

    // Write legalization
    csr_write(12'h3A0, 32'h0000_00E2);
    rd_check("legal_e2", 12'h3A0, 32'h0000_0080);
    csr_write(12'h3A0, 32'h0006_0700);
    rd_check("legal_wx", 12'h3A0, 32'h0004_0780);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end
endmodule
